sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock FIFO. It adds the following over that block:
- occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- synchronous flush;
- selectable standard or first-word-fall-through (FWFT) read mode.

It sits between producer and consumer datapaths inside one clock domain and buffers bursts.

Parameters:
DATA_WIDTH, 32, width of each stored word
FIFO_SIZE, 8, depth in words; must be a power of two and at least 2
SIZE_BITS, 3, log2(FIFO_SIZE); pointer width
AFULL_THRESH, FIFO_SIZE-2, almost_full asserts when count >= this value
AEMPTY_THRESH, 2, almost_empty asserts when count <= this value
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush; empties the FIFO without touching memory contents
data  input  DATA_WIDTH  write data
write_enable  input  1  write request
read_enable  input  1  read request (FWFT: pop the head word)
q  output  DATA_WIDTH  read data
fifo_full  output  1  count == FIFO_SIZE
fifo_empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  SIZE_BITS+1  current occupancy, 0..FIFO_SIZE
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset=1 at a clock edge), with highest priority:
  - read and write pointers = 0, count = 0, q = 0;
  - fifo_full = 0, fifo_empty = 1, almost_full = 0, almost_empty = 1;
  - overflow = 0, underflow = 0.
- Clear (clear=1, reset=0):
  - same as reset, except q and memory are untouched;
  - write_enable and read_enable are ignored in that cycle and do not set overflow or underflow.
- Write accept: write_enable & ~fifo_full.
  - mem[write_pointer] <= data; write_pointer increments and wraps modulo FIFO_SIZE.
  - Fullness is judged on the pre-edge state. A write while full is rejected even if a read is accepted in the same cycle. No data is modified; overflow is set.
- Read accept: read_enable & ~fifo_empty.
  - read_pointer increments and wraps modulo FIFO_SIZE.
  - A read while empty is rejected even if a write occurs in the same cycle; underflow is set.
- Count update: next count = count + write_accept - read_accept.
  - A simultaneous accepted read and write leaves count unchanged.
  - All flags derive from the registered count and update in the same edge as count, so there is no combinational path from the enables to the flags.
- Standard mode (FWFT=0):
  - on an accepted read, q <= mem[read_pointer] at that edge, so data is valid the cycle after the request;
  - q holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - q = mem[read_pointer] combinationally whenever fifo_empty=0; read_enable acknowledges and pops that word;
  - q is don't-care while empty;
  - write-to-visible latency is 1 cycle: fifo_empty falls on the edge after the write.
- Memory write is synchronous and memory read is asynchronous. A same-address read and write only occurs when the FIFO is empty, and that read is rejected, so no bypass is required.
- Overflow and underflow stay set until reset or clear.
- Thresholds are compared against the full-width count. Parameter values outside 0..FIFO_SIZE are an elaboration error.

Decomposition:
- Shared package/header fifo_defs holds:
  - FWFT mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1);
  - a helper constant function for log2 depth, checked against SIZE_BITS at elaboration.
- One sub-module, fifo_ram: simple dual-port RAM, DATA_WIDTH x FIFO_SIZE, synchronous write, asynchronous read.
- Pointer, count, flag and output-register logic stays in sync_fifo.

Test Plan:
1. Reset, then defaults. Hold reset 2 cycles, then release. Expect fifo_empty=1, almost_empty=1, count=0, q=0, fifo_full=0, overflow=0, underflow=0.
2. Fill and overflow. Write 0x00000001..0x00000008 on consecutive cycles. Expect count=6 and almost_full=1 after the 6th write, then fifo_full=1 and count=8. A 9th write of 0xDEADBEEF is rejected and overflow=1. Draining returns 1..8 in order, with no 0xDEADBEEF.
3. Standard-mode latency and underflow. After writing 0xA5A5A5A5, assert read_enable for 1 cycle. Expect q=0xA5A5A5A5 the next cycle and fifo_empty=1. A further read sets underflow=1 and q stays 0xA5A5A5A5.
4. Simultaneous read and write. With count=4, assert both enables for 10 cycles. Expect count to stay 4 and the output order to match the input order across pointer wrap, covering 10 writes past depth 8. Repeat at count=8: the read is accepted, the write is rejected, overflow=1, count=7.
5. FWFT. With FWFT=1, write 0x11111111; one cycle later q=0x11111111 with no read issued and fifo_empty=0. Pop with read_enable: fifo_empty=1, count=0.
6. Clear mid-operation. With count=5 and overflow=1, assert clear together with write_enable. Next cycle: count=0, fifo_empty=1, overflow=0, and the write is not stored. A subsequent write and read of 0x12345678 returns 0x12345678.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// fifo_defs: shared read-mode constants and depth helper for the single-clock FIFO
package fifo_defs;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    function automatic int fifo_log2(input int n);
        int r = 0;
        for (int i = 1; i < n; i = i * 2) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write and asynchronous read
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 8,
    parameter int SIZE_BITS  = 3
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [SIZE_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [SIZE_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    // store the incoming word; contents are never reset so flush leaves them intact
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, thresholds, sticky errors, flush and FWFT option
module sync_fifo
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_SIZE     = 8,
    parameter int SIZE_BITS     = 3,
    parameter int AFULL_THRESH  = FIFO_SIZE - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_STD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [SIZE_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = SIZE_BITS + 1;

    if (SIZE_BITS != fifo_log2(FIFO_SIZE)) begin : g_bad_bits
        $error("SIZE_BITS does not match log2(FIFO_SIZE)");
    end
    if (FIFO_SIZE < 2 || (FIFO_SIZE & (FIFO_SIZE - 1)) != 0) begin : g_bad_size
        $error("FIFO_SIZE must be a power of two and at least 2");
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > FIFO_SIZE || AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_SIZE) begin : g_bad_thresh
        $error("thresholds must lie within 0..FIFO_SIZE");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("FWFT must be 0 or 1");
    end

    logic [SIZE_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] q_q, q_d, rd_data;
    logic                  full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_acc, rd_acc, mem_we;

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_SIZE (FIFO_SIZE),
        .SIZE_BITS (SIZE_BITS)
    ) u_ram (
        .clock(clock),
        .we   (mem_we),
        .waddr(wr_ptr_q),
        .wdata(data),
        .raddr(rd_ptr_q),
        .rdata(rd_data)
    );

    // acceptance is judged on the registered flags; flush overrides both enables
    always_comb begin
        wr_acc   = write_enable & ~full_q;
        rd_acc   = read_enable & ~empty_q;
        mem_we   = wr_acc & ~clear & ~reset;
        wr_ptr_d = clear ? '0 : wr_ptr_q + SIZE_BITS'(wr_acc);
        rd_ptr_d = clear ? '0 : rd_ptr_q + SIZE_BITS'(rd_acc);
        count_d  = clear ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
        full_d   = count_d == CW'(FIFO_SIZE);
        empty_d  = count_d == '0;
        afull_d  = count_d >= CW'(AFULL_THRESH);
        aempty_d = count_d <= CW'(AEMPTY_THRESH);
        ovf_d    = ~clear & (ovf_q | (write_enable & full_q));
        udf_d    = ~clear & (udf_q | (read_enable & empty_q));
        q_d      = (rd_acc & ~clear) ? rd_data : q_q;
    end

    // state registers; reset wins over everything, including the output word
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign q            = (FWFT == FIFO_MODE_FWFT) ? rd_data : q_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: standard and FWFT instances driven together and checked against a queue model
module tb_sync_fifo;
    localparam int W = 32;
    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset, clear, we, re;
    logic [W-1:0] data;
    logic [W-1:0] q_s, q_f;
    logic         full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic         full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [3:0]   cnt_s, cnt_f;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_q;
    logic         m_ovf, m_udf;
    int           n_chk = 0;
    int           n_pass = 0;

    always #5 clock = ~clock;

    sync_fifo #(.DATA_WIDTH(W), .FIFO_SIZE(N), .SIZE_BITS(3), .FWFT(0)) u_std (
        .clock(clock), .reset(reset), .clear(clear), .data(data),
        .write_enable(we), .read_enable(re), .q(q_s),
        .fifo_full(full_s), .fifo_empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
        .count(cnt_s), .overflow(ovf_s), .underflow(udf_s)
    );

    sync_fifo #(.DATA_WIDTH(W), .FIFO_SIZE(N), .SIZE_BITS(3), .FWFT(1)) u_fwft (
        .clock(clock), .reset(reset), .clear(clear), .data(data),
        .write_enable(we), .read_enable(re), .q(q_f),
        .fifo_full(full_f), .fifo_empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(cnt_f), .overflow(ovf_f), .underflow(udf_f)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        int c;
        c = mq.size();
        chk("count_s", 64'(cnt_s), 64'(c));
        chk("count_f", 64'(cnt_f), 64'(c));
        chk("full_s", 64'(full_s), 64'(c == N));
        chk("full_f", 64'(full_f), 64'(c == N));
        chk("empty_s", 64'(empty_s), 64'(c == 0));
        chk("empty_f", 64'(empty_f), 64'(c == 0));
        chk("afull_s", 64'(af_s), 64'(c >= N - 2));
        chk("afull_f", 64'(af_f), 64'(c >= N - 2));
        chk("aempty_s", 64'(ae_s), 64'(c <= 2));
        chk("aempty_f", 64'(ae_f), 64'(c <= 2));
        chk("ovf_s", 64'(ovf_s), 64'(m_ovf));
        chk("ovf_f", 64'(ovf_f), 64'(m_ovf));
        chk("udf_s", 64'(udf_s), 64'(m_udf));
        chk("udf_f", 64'(udf_f), 64'(m_udf));
        chk("q_std", 64'(q_s), 64'(m_q));
        if (c > 0) chk("q_fwft", 64'(q_f), 64'(mq[0]));
    endtask

    task automatic step(input logic w, input logic r, input logic cl, input logic rs, input logic [W-1:0] d);
        bit was_full, was_empty;
        we = w; re = r; clear = cl; reset = rs; data = d;
        @(posedge clock);
        was_full  = mq.size() == N;
        was_empty = mq.size() == 0;
        if (rs) begin
            mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_q = '0;
        end else if (cl) begin
            mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (w && was_full) m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_q = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
        // reset and defaults
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_q", 64'(q_s), 64'h0);
        // fill and overflow
        for (int i = 1; i <= N; i++) begin
            step(1, 0, 0, 0, W'(i));
            if (i == 6) chk("afull_at6", 64'(af_s), 64'h1);
        end
        chk("full_at8", 64'(full_s), 64'h1);
        step(1, 0, 0, 0, 32'hDEADBEEF);
        chk("ovf_9th", 64'(ovf_s), 64'h1);
        for (int i = 1; i <= N; i++) begin
            step(0, 1, 0, 0, 0);
            chk("drain", 64'(q_s), 64'(i));
        end
        // standard latency and underflow
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 32'hA5A5A5A5);
        step(0, 1, 0, 0, 0);
        chk("std_q", 64'(q_s), 64'hA5A5A5A5);
        chk("std_empty", 64'(empty_s), 64'h1);
        step(0, 1, 0, 0, 0);
        chk("udf_set", 64'(udf_s), 64'h1);
        chk("udf_q_hold", 64'(q_s), 64'hA5A5A5A5);
        // simultaneous read and write across wrap
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, W'(32'h100 + i));
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, W'(32'h200 + i));
        chk("rw_count4", 64'(cnt_s), 64'h4);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, W'(32'h300 + i));
        step(1, 1, 0, 0, 32'hBAD0BAD0);
        chk("rw_full_ovf", 64'(ovf_s), 64'h1);
        chk("rw_full_cnt", 64'(cnt_s), 64'h7);
        // first-word-fall-through
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 32'h11111111);
        chk("fwft_q", 64'(q_f), 64'h11111111);
        chk("fwft_nonempty", 64'(empty_f), 64'h0);
        step(0, 1, 0, 0, 0);
        chk("fwft_pop_empty", 64'(empty_f), 64'h1);
        chk("fwft_pop_cnt", 64'(cnt_f), 64'h0);
        // clear mid-operation
        for (int i = 0; i < N + 1; i++) step(1, 0, 0, 0, W'(32'h400 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("pre_clr_cnt", 64'(cnt_s), 64'h5);
        step(1, 0, 1, 0, 32'hCAFEF00D);
        chk("clr_cnt", 64'(cnt_s), 64'h0);
        chk("clr_ovf", 64'(ovf_s), 64'h0);
        step(1, 0, 0, 0, 32'h12345678);
        step(0, 1, 0, 0, 0);
        chk("post_clr_q", 64'(q_s), 64'h12345678);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0, $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
